pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-carry adder built from chunk adders, one carry chunk resolved per stage.
- Successor to the fixed-delay gate-level half adders. It replaces modelled gate delays with registered, cycle-accurate latency and a valid/ready handshake on both sides.
- Serves as the standard wide adder for datapath blocks that need full throughput at high clock rates.

Parameters:
- WIDTH, 16: operand width in bits. Must be at least 2.
- STAGES, 4: number of pipeline stages, which equals latency in cycles. Must be at least 1, and WIDTH % STAGES must be 0.
- CHUNK, WIDTH/STAGES: bits resolved per stage. This is derived and must not be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts the beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- sum  out  WIDTH  a+b+cin, modulo 2^WIDTH
- cout  out  1  unsigned carry out of the MSB
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset: one clock with rst=1 clears every stage valid bit.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset.
  - Data registers other than the outputs are don't-care.
- Stage i (0..STAGES-1):
  - Adds a[i*CHUNK +: CHUNK] + b[i*CHUNK +: CHUNK] + carry_in.
  - Stage 0 takes its carry from cin; stage i takes it from stage i-1's registered carry.
  - Registers the partial sum and carry, and forwards the not-yet-consumed upper operand bits.
- Final stage:
  - cout = carry out of the final chunk.
  - ovf = carry into MSB XOR carry out of MSB.
  - ovf equals (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Advance rule: per-stage enable en[i] = !valid[i+1] || en[i+1], with en[STAGES] = out_ready.
  - Bubbles collapse: a stage with valid=0 always accepts.
  - in_ready = !valid[0] || en[1]. This is combinational from out_ready; no registered skid.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Latency: an accepted beat appears on the outputs exactly STAGES cycles later if no stall occurs.
- Throughput: 1 beat/cycle when out_ready=1.
- Capacity: at most STAGES beats in flight. in_ready=0 only when all stages are valid and out_ready=0.
- Output stability: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
- Ordering: strict FIFO. No reordering, dropping or duplication.
- Simultaneous events:
  - An output drain and an input accept in the same cycle are both honoured when the pipeline is full and out_ready=1.
  - rst overrides both.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops in the next cycle. Nothing is emitted after reset deasserts unless new input is accepted.
- in_valid while in_ready=0: the beat is not taken. The sender must hold it.
- Wrap-around: the sum is modulo 2^WIDTH. The lost carry is reported only on cout.
- STAGES=1 degenerates to a registered adder with 1-cycle latency. This configuration must be supported.

Decomposition:
- Package pipe_adder_pkg holds:
  - a stage-record typedef builder (valid, partial sum, carry, remaining operands), parametrised via a WIDTH-generic struct in a class-free form using localparams;
  - the function chunk_count(WIDTH, STAGES);
  - elaboration-time checks for the WIDTH/STAGES legality rules.
- Sub-module pipe_adder_chunk: combinational CHUNK-bit adder, chained half/full-adder cells, producing sum, carry out and carry into MSB. The top instantiates one per stage with a generate loop.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- 100 back-to-back random beats with out_ready=1 -> 100 results in order, 1/cycle, first result exactly 4 cycles after the first accept. Checked against a golden a+b+cin model.
- out_ready=0 for 10 cycles while feeding continuously -> 4 beats accepted, then in_ready=0; outputs stable. Release -> all results in order, no loss.
- rst=1 for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, in_ready=1, no stale result ever emitted.
- STAGES=1, WIDTH=8: a=0x80, b=0xFF, cin=1 -> 1 cycle later sum=0x80, cout=1, ovf=0.

Source files
------------

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared types and elaboration helpers for the pipelined adder.
//   stage_flags_t  : per-stage control/status bits (valid, carry, overflow).
//                    The top wraps it with WIDTH-sized data fields to build
//                    its stage record.
//   chunk_count()  : bits resolved per pipeline stage.
//   config_ok()    : legality of a WIDTH/STAGES pair.
package pipe_adder_pkg;

  // Width-independent part of a stage record. The top builds the full record
  // from this plus its own WIDTH-sized partial sum and remaining operands.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_flags_t;

  // Bits resolved per stage. Guarded so an illegal STAGES=0 reports through
  // config_ok() instead of failing on a divide by zero.
  function automatic int chunk_count(input int width, input int stages);
    return (stages < 1) ? 1 : width / stages;
  endfunction

  function automatic bit config_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_chunk.sv
// pipe_adder_chunk: combinational CHUNK-bit ripple adder built from chained
// full-adder cells (each a pair of half adders plus an OR).
//   a, b   : chunk operands
//   cin    : carry into bit 0
//   sum    : chunk sum
//   cout   : carry out of the chunk MSB
//   c_msb  : carry into the chunk MSB (used for signed overflow)
module pipe_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] carry;

  // The ripple chain lives in one process so the carry vector is not split
  // across many tiny continuous assignments.
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      // first half adder: propagate/generate; second: fold in the carry
      sum[i]       = (a[i] ^ b[i]) ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & carry[i]);
    end
  end

  assign cout  = carry[CHUNK];
  assign c_msb = carry[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined ripple-carry adder, one CHUNK-bit slice resolved per
// stage, with valid/ready handshakes on input and output.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : input handshake for operands a, b and cin
//   out_valid/out_ready : output handshake for sum, cout, ovf
//   sum                 : a+b+cin modulo 2^WIDTH
//   cout                : unsigned carry out of the MSB
//   ovf                 : two's-complement signed overflow
// Latency is STAGES cycles; throughput one beat per cycle while out_ready=1.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_count(WIDTH, STAGES);

  generate
    if (!config_ok(WIDTH, STAGES)) begin : g_bad_config
      $error("pipe_adder: WIDTH must be >= 2, STAGES >= 1, WIDTH %% STAGES == 0");
    end
  endgenerate

  // Stage record: control flags plus the accumulated low sum bits and the
  // operands forwarded for the chunks still to be added.
  typedef struct packed {
    stage_flags_t     flags;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] rem_a;
    logic [WIDTH-1:0] rem_b;
  } stage_t;

  stage_t stage_reg  [STAGES];
  stage_t stage_next [STAGES];

  // What each stage sees on its input side: the ports for stage 0, the
  // previous stage's registers otherwise.
  logic [STAGES-1:0]            op_valid;
  logic [STAGES-1:0]            op_cin;
  logic [STAGES-1:0][WIDTH-1:0] op_a;
  logic [STAGES-1:0][WIDTH-1:0] op_b;
  logic [STAGES-1:0][WIDTH-1:0] op_psum;

  logic [STAGES-1:0][CHUNK-1:0] ch_sum;
  logic [STAGES-1:0]            ch_cout;
  logic [STAGES-1:0]            ch_cmsb;

  // load[i]: stage i captures its input this cycle. load[STAGES] is the
  // consumer; an empty stage always loads, so bubbles collapse.
  logic [STAGES:0] load;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign op_valid[gi] = in_valid;
        assign op_cin[gi]   = cin;
        assign op_a[gi]     = a;
        assign op_b[gi]     = b;
        assign op_psum[gi]  = '0;
      end else begin : g_next
        assign op_valid[gi] = stage_reg[gi-1].flags.valid;
        assign op_cin[gi]   = stage_reg[gi-1].flags.carry;
        assign op_a[gi]     = stage_reg[gi-1].rem_a;
        assign op_b[gi]     = stage_reg[gi-1].rem_b;
        assign op_psum[gi]  = stage_reg[gi-1].psum;
      end

      pipe_adder_chunk #(
        .CHUNK (CHUNK)
      ) u_chunk (
        .a     (op_a[gi][gi*CHUNK +: CHUNK]),
        .b     (op_b[gi][gi*CHUNK +: CHUNK]),
        .cin   (op_cin[gi]),
        .sum   (ch_sum[gi]),
        .cout  (ch_cout[gi]),
        .c_msb (ch_cmsb[gi])
      );
    end
  endgenerate

  always_comb begin
    load         = '0;
    load[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = !stage_reg[i].flags.valid || load[i + 1];
    end
  end

  // Next record per stage. The ovf flag is only meaningful in the last stage,
  // where the chunk MSB is the word MSB.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_next[i]                        = '0;
      stage_next[i].flags.valid            = op_valid[i];
      stage_next[i].flags.carry            = ch_cout[i];
      stage_next[i].flags.ovf              = ch_cout[i] ^ ch_cmsb[i];
      stage_next[i].psum                   = op_psum[i];
      stage_next[i].psum[i*CHUNK +: CHUNK] = ch_sum[i];
      stage_next[i].rem_a                  = op_a[i];
      stage_next[i].rem_b                  = op_b[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          stage_reg[i] <= stage_next[i];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = stage_reg[STAGES-1].flags.valid;
  assign sum       = stage_reg[STAGES-1].psum;
  assign cout      = stage_reg[STAGES-1].flags.carry;
  assign ovf       = stage_reg[STAGES-1].flags.ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of pipe_adder (16-bit/4-stage and
// 8-bit/1-stage instances). Inputs change 1 time unit after the rising edge;
// outputs are sampled there too, away from the edge.
module tb_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]   a8, b8, sum8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  // Directed vectors: a, b, cin -> sum, cout, ovf (hand computed).
  logic [15:0] dir_a    [7] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h00FF, 16'hFFFF, 16'h8000};
  logic [15:0] dir_b    [7] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321, 16'h0001, 16'h0000, 16'hFFFF};
  logic        dir_c    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] dir_sum  [7] = '{16'h0000, 16'h8000, 16'h0000, 16'h5556, 16'h0100, 16'h0000, 16'h7FFF};
  logic        dir_cout [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        dir_ovf  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  // Stall scenario beats (hand computed).
  logic [15:0] st_a    [6] = '{16'h0001, 16'h00F0, 16'h0FFF, 16'h4000, 16'hF000, 16'hABCD};
  logic [15:0] st_b    [6] = '{16'h0002, 16'h0010, 16'h0001, 16'h4000, 16'h1000, 16'h1111};
  logic        st_c    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] st_sum  [6] = '{16'h0003, 16'h0100, 16'h1001, 16'h8000, 16'h0000, 16'hBCDF};
  logic        st_cout [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        st_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h want 0000", sum); end
    total++; if ({cout, ovf} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {cout, ovf}); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if ({out_valid8, sum8, cout8, ovf8} !== 11'h0) begin bad++; $display("FAIL reset_dut8_outputs: got %h want 000", {out_valid8, sum8, cout8, ovf8}); end
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_dut8_in_ready: got %b want 1", in_ready8); end
    $display("reset: out_valid=%b sum=%h in_ready=%b", out_valid, sum, in_ready);
  endtask

  task automatic test_directed();
    for (int v = 0; v < 7; v++) begin
      out_ready = 1'b1;
      in_valid = 1'b1; a = dir_a[v]; b = dir_b[v]; cin = dir_c[v];
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready: got %b want 1", v, in_ready); end
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= S; c++) begin
        if (c > 1) tick();
        if (c < S) begin
          total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid cycle %0d: got %b want 0", v, c, out_valid); end
        end else begin
          total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency: got out_valid=%b want 1", v, out_valid); end
          total++; if ({sum, cout, ovf} !== {dir_sum[v], dir_cout[v], dir_ovf[v]})
            begin bad++; $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                  v, sum, cout, ovf, dir_sum[v], dir_cout[v], dir_ovf[v]); end
          $display("directed %0d: %h+%h+%b -> sum=%h cout=%b ovf=%b", v, dir_a[v], dir_b[v], dir_c[v], sum, cout, ovf);
        end
      end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_duplicate: got out_valid=%b want 0", v, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba [100];
    logic [15:0] bb [100];
    logic        bc [100];
    logic [16:0] full;
    logic        exp_v, exp_ovf;
    int          idx;
    for (int i = 0; i < 100; i++) begin
      ba[i] = 16'($urandom);
      bb[i] = 16'($urandom);
      bc[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    for (int j = 0; j <= 104; j++) begin
      exp_v = (j >= S) && (j <= 99 + S);
      total++; if (out_valid !== exp_v) begin bad++; $display("FAIL b2b_valid step %0d: got %b want %b", j, out_valid, exp_v); end
      if (out_valid && exp_v) begin
        idx     = j - S;
        full    = {1'b0, ba[idx]} + {1'b0, bb[idx]} + 17'(bc[idx]);
        exp_ovf = (ba[idx][15] == bb[idx][15]) && (full[15] != ba[idx][15]);
        total++; if ({cout, sum, ovf} !== {full, exp_ovf})
          begin bad++; $display("FAIL b2b_result beat %0d: got cout=%b sum=%h ovf=%b want cout=%b sum=%h ovf=%b",
                                idx, cout, sum, ovf, full[16], full[15:0], exp_ovf); end
        $display("b2b beat %0d: sum=%h cout=%b ovf=%b", idx, sum, cout, ovf);
      end
      if (j < 100) begin
        in_valid = 1'b1; a = ba[j]; b = bb[j]; cin = bc[j];
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready step %0d: got %b want 1", j, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int  k    = 0;
    int  nidx = 0;
    logic exp_rdy;
    for (int j = 0; j < 30; j++) begin
      out_ready = (j >= 10);
      if (j >= S && j <= 9) begin
        total++; if ({out_valid, sum, cout, ovf} !== {1'b1, st_sum[0], st_cout[0], st_ovf[0]})
          begin bad++; $display("FAIL stall_hold step %0d: got valid=%b sum=%h cout=%b ovf=%b want valid=1 sum=%h cout=%b ovf=%b",
                                j, out_valid, sum, cout, ovf, st_sum[0], st_cout[0], st_ovf[0]); end
      end
      if (j >= 10 && out_valid) begin
        if (nidx < 6) begin
          total++; if ({sum, cout, ovf} !== {st_sum[nidx], st_cout[nidx], st_ovf[nidx]})
            begin bad++; $display("FAIL stall_drain beat %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                                  nidx, sum, cout, ovf, st_sum[nidx], st_cout[nidx], st_ovf[nidx]); end
          $display("stall drain %0d: sum=%h cout=%b ovf=%b", nidx, sum, cout, ovf);
          nidx++;
        end else begin
          total++; bad++; $display("FAIL stall_extra_beat: got sum=%h want no output", sum);
        end
      end
      if (k < 6) begin
        in_valid = 1'b1; a = st_a[k]; b = st_b[k]; cin = st_c[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (j < 10) begin
        exp_rdy = (j < S);
        total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL stall_in_ready step %0d: got %b want %b", j, in_ready, exp_rdy); end
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    total++; if (k !== 6) begin bad++; $display("FAIL stall_accepted: got %0d want 6", k); end
    total++; if (nidx !== 6) begin bad++; $display("FAIL stall_delivered: got %0d want 6", nidx); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; a = dir_a[j]; b = dir_b[j]; cin = dir_c[j];
      tick();
    end
    rst = 1'b1; in_valid = 1'b1; a = 16'h0101; b = 16'h0101; cin = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    total++; if ({sum, cout, ovf} !== 18'h0) begin bad++; $display("FAIL flush_outputs: got sum=%h cout=%b ovf=%b want 0", sum, cout, ovf); end
    for (int j = 0; j < 8; j++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale step %0d: got out_valid=%b sum=%h want 0", j, out_valid, sum); end
    end
    in_valid = 1'b1; a = 16'h0005; b = 16'h0003; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int j = 1; j < S; j++) tick();
    total++; if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h0008, 2'b00})
      begin bad++; $display("FAIL flush_restart: got valid=%b sum=%h cout=%b ovf=%b want valid=1 sum=0008 cout=0 ovf=0",
                            out_valid, sum, cout, ovf); end
    $display("flush restart: sum=%h", sum);
    tick();
  endtask

  task automatic test_stages1();
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'hFF; cin8 = 1'b1;
    #1;
    total++; if ({out_valid8, in_ready8} !== 2'b01) begin bad++; $display("FAIL s1_idle: got valid=%b ready=%b want 0 1", out_valid8, in_ready8); end
    tick();
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    total++; if ({out_valid8, sum8, cout8, ovf8} !== {1'b1, 8'h80, 1'b1, 1'b0})
      begin bad++; $display("FAIL s1_vec0: got valid=%b sum=%h cout=%b ovf=%b want 1 80 1 0", out_valid8, sum8, cout8, ovf8); end
    $display("stages1 vec0: sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
    tick();
    in_valid8 = 1'b0;
    total++; if ({out_valid8, sum8, cout8, ovf8} !== {1'b1, 8'h80, 1'b0, 1'b1})
      begin bad++; $display("FAIL s1_vec1: got valid=%b sum=%h cout=%b ovf=%b want 1 80 0 1", out_valid8, sum8, cout8, ovf8); end
    $display("stages1 vec1: sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
    tick();
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL s1_drained: got %b want 0", out_valid8); end
    out_ready8 = 1'b0; in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    tick();
    a8 = 8'h10; b8 = 8'h20;
    #1;
    total++; if ({in_ready8, out_valid8, sum8} !== {1'b0, 1'b1, 8'h03})
      begin bad++; $display("FAIL s1_full: got ready=%b valid=%b sum=%h want 0 1 03", in_ready8, out_valid8, sum8); end
    tick();
    total++; if ({in_ready8, out_valid8, sum8} !== {1'b0, 1'b1, 8'h03})
      begin bad++; $display("FAIL s1_hold: got ready=%b valid=%b sum=%h want 0 1 03", in_ready8, out_valid8, sum8); end
    out_ready8 = 1'b1;
    #1;
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL s1_passthru_ready: got %b want 1", in_ready8); end
    tick();
    in_valid8 = 1'b0;
    total++; if ({out_valid8, sum8} !== {1'b1, 8'h30}) begin bad++; $display("FAIL s1_after_stall: got valid=%b sum=%h want 1 30", out_valid8, sum8); end
    $display("stages1 after stall: sum=%h", sum8);
    tick();
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL s1_end: got %b want 0", out_valid8); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_stages1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
